// File: rtl/usr_pkg.sv
// Shared types and default widths for the USR command sequencer.
package usr_pkg;

  localparam int unsigned USR_WIDTH = 4;
  localparam int unsigned USR_CNT_W = 3;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } usr_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXEC   = 2'b01,
    SETTLE = 2'b10,
    RESP   = 2'b11
  } usr_state_e;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command/response valid-ready bundle between a host and the USR sequencer.
interface usr_seq_ctrl_if
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = USR_WIDTH,
  parameter int unsigned CNT_W = USR_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/usr_step_cnt.sv
// Loadable step down-counter; last flags the cycle in which the count reads 1.
module usr_step_cnt
  import usr_pkg::*;
#(
  parameter int unsigned CNT_W = USR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  // Decrement stops at zero so a stray enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    last_d = (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/usr_seq_ctrl.sv
// Sequencer that runs one load/shift/hold command on a USR and returns the captured q.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = USR_WIDTH,
  parameter int unsigned CNT_W = USR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  usr_seq_ctrl_if.slave    bus,
  output logic             busy,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q
);

  usr_state_e       state_q, state_d;
  logic [1:0]       usr_ctrl_q, usr_ctrl_d;
  logic [WIDTH-1:0] usr_d_q, usr_d_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  usr_op_e          cmd_op_c;
  logic             cmd_ready_c;
  logic             accept_c;
  logic             zero_step_c;
  logic             cnt_en_c;
  logic [CNT_W-1:0] cnt_load_val_c;
  logic             cnt_last;

  assign cmd_op_c       = usr_op_e'(bus.cmd_op);
  assign cmd_ready_c    = (state_q == IDLE) && !rst;
  assign accept_c       = bus.cmd_valid && cmd_ready_c;
  assign zero_step_c    = (cmd_op_c != LOAD) && (bus.cmd_cnt == '0);
  assign cnt_en_c       = (state_q == EXEC);
  assign cnt_load_val_c = (cmd_op_c == LOAD) ? CNT_W'(1) : bus.cmd_cnt;

  usr_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .load_val (cnt_load_val_c),
    .en       (cnt_en_c),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      usr_ctrl_q  <= 2'b00;
      usr_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      usr_ctrl_q  <= usr_ctrl_d;
      usr_d_q     <= usr_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = zero_step_c ? SETTLE : EXEC;
      EXEC:    if (cnt_last) state_d = SETTLE;
      SETTLE:  state_d = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The USR pins are registered, so the op is staged on the accept edge and dropped on the last step.
  always_comb begin
    usr_ctrl_d  = 2'b00;
    usr_d_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept_c && !zero_step_c) begin
          usr_ctrl_d = bus.cmd_op;
          case (cmd_op_c)
            LOAD:     usr_d_d = bus.cmd_data;
            SHR, SHL: usr_d_d = {WIDTH{bus.cmd_data[0]}};
            default:  usr_d_d = '0;
          endcase
        end
      end
      EXEC: begin
        if (!cnt_last) begin
          usr_ctrl_d = usr_ctrl_q;
          usr_d_d    = usr_d_q;
        end
      end
      SETTLE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = usr_q;
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign usr_ctrl      = usr_ctrl_q;
  assign usr_d         = usr_d_q;
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: USR model on the pins, per-cycle reference model, directed and random commands.
module tb_usr_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy;
  logic [1:0]   usr_ctrl;
  logic [W-1:0] usr_d;
  logic [W-1:0] usr_q = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  usr_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .usr_ctrl (usr_ctrl),
    .usr_d    (usr_d),
    .usr_q    (usr_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] usr_next(input logic [W-1:0] q, input logic [1:0] c,
                                            input logic [W-1:0] d);
    case (c)
      2'b01:   return {d[W-1], q[W-1:1]};
      2'b10:   return {q[W-2:0], d[0]};
      2'b11:   return d;
      default: return q;
    endcase
  endfunction

  // USR attached to the controller pins; not reset, so it keeps q across a controller reset.
  always @(posedge clk) if (cyc > 0) usr_q <= usr_next(usr_q, usr_ctrl, usr_d);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: a command accepted at edge A with n steps shows its op for cycles A..A+n-1
  // and raises its response at edge A+n+1; everything is relative to the accept edge.
  logic         m_busy = 1'b0;
  logic [1:0]   m_op   = 2'b00;
  int           m_n    = 0;
  int           m_acc  = 0;
  logic [W-1:0] m_dpin = '0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_rsp  = '0;
  logic [W-1:0] m_pend = '0;

  always @(negedge clk) begin
    int           j;
    logic [1:0]   ctrl_e;
    logic         exec_e;
    logic         valid_e;
    if (cyc >= 1) begin
      j       = cyc - m_acc;
      exec_e  = m_busy && (j < m_n);
      ctrl_e  = exec_e ? m_op : 2'b00;
      valid_e = m_busy && (j >= m_n + 1);
      if (valid_e) m_rsp = m_pend;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy && !rst));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("usr_ctrl", 32'(usr_ctrl), 32'(ctrl_e));
      if (exec_e) chk("usr_d", 32'(usr_d), 32'(m_dpin));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(valid_e));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp));
      chk("usr_q", 32'(usr_q), 32'(m_q));
      m_q = usr_next(m_q, ctrl_e, m_dpin);
      if (rst) begin
        m_busy = 1'b0;
        m_rsp  = '0;
      end else if (valid_e && bus.rsp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && bus.cmd_valid) begin
        m_busy = 1'b1;
        m_op   = bus.cmd_op;
        m_acc  = cyc + 1;
        m_n    = (bus.cmd_op == 2'b11) ? 1 : int'(bus.cmd_cnt);
        case (bus.cmd_op)
          2'b11:        m_dpin = bus.cmd_data;
          2'b01, 2'b10: m_dpin = {W{bus.cmd_data[0]}};
          default:      m_dpin = '0;
        endcase
        m_pend = m_q;
        for (int k = 0; k < m_n; k++) m_pend = usr_next(m_pend, m_op, m_dpin);
      end
    end
  end

  task automatic junk_cmd();
    bus.cmd_op   = 2'($urandom);
    bus.cmd_cnt  = CW'($urandom);
    bus.cmd_data = W'($urandom);
  endtask

  task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data);
    int t;
    t = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.cmd_data  = data;
    do begin
      @(negedge clk);
      t++;
    end while (bus.cmd_ready !== 1'b1 && t < 40);
    if (t >= 40) chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc       = cyc;
    bus.cmd_valid = 1'b0;
    junk_cmd();
  endtask

  task automatic wait_rsp(input int hold, output logic [W-1:0] data, output int lat);
    data = '0;
    lat  = -1;
    bus.rsp_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat  = cyc - acc_cyc;
        data = bus.rsp_data;
        break;
      end
      @(posedge clk); #1;
      junk_cmd();
    end
    if (lat < 0) chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    int           lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_cnt   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(2'b11, 3'd0, 4'b1011); wait_rsp(0, d, lat);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_data", 32'(d), 32'(4'b1011));

    send(2'b01, 3'd2, 4'b0000); wait_rsp(0, d, lat);
    chk("shr2_lat", 32'(lat), 32'd3);
    chk("shr2_data", 32'(d), 32'(4'b0010));

    send(2'b11, 3'd0, 4'b1011); wait_rsp(0, d, lat);
    send(2'b10, 3'd1, 4'b0001); wait_rsp(0, d, lat);
    chk("shl1_lat", 32'(lat), 32'd2);
    chk("shl1_data", 32'(d), 32'(4'b0111));

    send(2'b10, 3'd0, 4'b0001); wait_rsp(0, d, lat);
    chk("shl0_lat", 32'(lat), 32'd1);
    chk("shl0_data", 32'(d), 32'(4'b0111));

    // Stalled response, then an immediate follow-on load and a back-to-back hold.
    send(2'b01, 3'd1, 4'b0000); wait_rsp(5, d, lat);
    chk("stall_data", 32'(d), 32'(4'b0011));
    send(2'b11, 3'd5, 4'b0001); wait_rsp(0, d, lat);
    send(2'b00, 3'd3, 4'b1111); wait_rsp(0, d, lat);
    chk("hold3_lat", 32'(lat), 32'd4);
    chk("hold3_data", 32'(d), 32'(4'b0001));

    // Reset sampled at the edge that would start the third shift.
    send(2'b11, 3'd0, 4'b1111); wait_rsp(0, d, lat);
    send(2'b01, 3'd7, 4'b1110);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(usr_q), 32'(4'b0011));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    send(2'b10, 3'd7, 4'b0001); wait_rsp(1, d, lat);
    chk("shl7_lat", 32'(lat), 32'd8);
    chk("shl7_data", 32'(d), 32'(4'b1111));

    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      op = 2'($urandom);
      send(op, CW'($urandom), W'($urandom));
      wait_rsp(int'($urandom_range(0, 3)), d, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
